// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants, register field layouts and helpers for CP0.
//   Register indices, ExcCode values, reset/handler vectors, writable-field
//   mask for SR, and packed layouts of the SR and Cause state actually held.
package cp0_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned EXC_W     = 5;
  localparam int unsigned HW_INT_W  = 6;

  // Register indices
  localparam logic [REG_IDX_W-1:0] CP0_BADVADDR = 5'd8;
  localparam logic [REG_IDX_W-1:0] CP0_COUNT    = 5'd9;
  localparam logic [REG_IDX_W-1:0] CP0_COMPARE  = 5'd11;
  localparam logic [REG_IDX_W-1:0] CP0_SR       = 5'd12;
  localparam logic [REG_IDX_W-1:0] CP0_CAUSE    = 5'd13;
  localparam logic [REG_IDX_W-1:0] CP0_EPC      = 5'd14;
  localparam logic [REG_IDX_W-1:0] CP0_PRID     = 5'd15;

  // ExcCode values
  localparam logic [EXC_W-1:0] EXC_INT     = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL    = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES    = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYSCALL = 5'd8;
  localparam logic [EXC_W-1:0] EXC_RI      = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV      = 5'd12;

  localparam logic [XLEN-1:0] RESET_PC     = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] HANDLER_PC   = 32'hBFC0_0380;
  localparam logic [XLEN-1:0] PRID_DEFAULT = 32'h0000_4C3A;

  // SR fields that exist: IM[15:10], EXL[1], IE[0]
  typedef struct packed {
    logic [HW_INT_W-1:0] im;
    logic                exl;
    logic                ie;
  } sr_t;

  // Cause fields that exist: BD[31], IP[15:10], ExcCode[6:2]
  typedef struct packed {
    logic                bd;
    logic [HW_INT_W-1:0] ip;
    logic [EXC_W-1:0]    exc_code;
  } cause_t;

  // Address-error codes are the only ones that capture BadVAddr
  function automatic logic is_addr_exc(input logic [EXC_W-1:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_if.sv
// cp0_if: pipeline-side bus of CP0.
//   Inputs to CP0 : en, cp0_addr, cp0_in (mtc0), vpc, bd_in, exc_in,
//                   badvaddr_in (M-stage exception info), hw_int, exl_clr.
//   Outputs of CP0: cp0_out (mfc0, combinational), req (flush/redirect,
//                   combinational), epc_out, handler_pc.
//   slave modport is CP0 itself, master is the pipeline driving it.
interface cp0_if;
  import cp0_pkg::*;

  logic                 en;
  logic [REG_IDX_W-1:0] cp0_addr;
  logic [XLEN-1:0]      cp0_in;
  logic [XLEN-1:0]      cp0_out;
  logic [XLEN-1:0]      vpc;
  logic                 bd_in;
  logic [EXC_W-1:0]     exc_in;
  logic [XLEN-1:0]      badvaddr_in;
  logic [HW_INT_W-1:0]  hw_int;
  logic                 exl_clr;
  logic                 req;
  logic [XLEN-1:0]      epc_out;
  logic [XLEN-1:0]      handler_pc;

  modport slave (
    input  en, cp0_addr, cp0_in, vpc, bd_in, exc_in, badvaddr_in, hw_int, exl_clr,
    output cp0_out, req, epc_out, handler_pc
  );

  modport master (
    output en, cp0_addr, cp0_in, vpc, bd_in, exc_in, badvaddr_in, hw_int, exl_clr,
    input  cp0_out, req, epc_out, handler_pc
  );

endinterface

// File: rtl/cp0_req_arb.sv
// cp0_req_arb: combinational arbitration of interrupts vs. synchronous exceptions.
//   Inputs : reset, effective interrupt lines, SR.IM/IE/EXL, M-stage ExcCode.
//   Outputs: req_c (take something this cycle), sel_code_c (ExcCode to record).
//   Interrupts win over exceptions; everything is masked while EXL=1.
module cp0_req_arb
  import cp0_pkg::*;
(
  input  logic                reset,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic [HW_INT_W-1:0] im,
  input  logic                ie,
  input  logic                exl,
  input  logic [EXC_W-1:0]    exc_in,
  output logic                req_c,
  output logic [EXC_W-1:0]    sel_code_c
);

  logic int_req_c;
  logic exc_req_c;

  always_comb begin
    int_req_c  = 1'b0;
    exc_req_c  = 1'b0;
    req_c      = 1'b0;
    sel_code_c = EXC_INT;

    int_req_c  = (|(hw_int & im)) & ie & ~exl;
    exc_req_c  = (exc_in != EXC_INT) & ~exl;
    req_c      = ~reset & (int_req_c | exc_req_c);
    sel_code_c = int_req_c ? EXC_INT : exc_in;
  end

endmodule

// File: rtl/cp0.sv
// cp0: MIPS system coprocessor 0, sitting beside the M stage.
//   Ports: clk, reset (synchronous, active-high), bus (cp0_if.slave).
//   Holds SR/Cause/EPC/BadVAddr/PRId, raises req for interrupts/exceptions,
//   serves mfc0 (combinational read of pre-edge state), mtc0 and eret.
//   Optional macro CP0_COUNT_EN adds Count(9)/Compare(11) and a timer
//   interrupt ORed onto hw_int[5].
module cp0 #(
  parameter logic [31:0] PRID       = cp0_pkg::PRID_DEFAULT,
  parameter logic [31:0] HANDLER_PC = cp0_pkg::HANDLER_PC
) (
  input  logic      clk,
  input  logic      reset,
  cp0_if.slave      bus
);
  import cp0_pkg::*;

  sr_t             sr_q,    sr_d;
  cause_t          cause_q, cause_d;
  logic [XLEN-1:0] epc_q,   epc_d;
  logic [XLEN-1:0] badv_q,  badv_d;

  logic [HW_INT_W-1:0] hw_eff_c;
  logic                req_c;
  logic [EXC_W-1:0]    sel_code_c;
  logic [XLEN-1:0]     vpc_al_c;

`ifdef CP0_COUNT_EN
  logic [XLEN-1:0] count_q,   count_d;
  logic [XLEN-1:0] compare_q, compare_d;
  logic            tp_q,      tp_d;
  logic            timer_c;

  // Pending is visible in the same cycle Count matches, then held until Compare is written
  assign timer_c  = tp_q | (count_q == compare_q);
  assign hw_eff_c = {bus.hw_int[HW_INT_W-1] | timer_c, bus.hw_int[HW_INT_W-2:0]};
`else
  assign hw_eff_c = bus.hw_int;
`endif

  cp0_req_arb u_arb (
    .reset      (reset),
    .hw_int     (hw_eff_c),
    .im         (sr_q.im),
    .ie         (sr_q.ie),
    .exl        (sr_q.exl),
    .exc_in     (bus.exc_in),
    .req_c      (req_c),
    .sel_code_c (sel_code_c)
  );

  assign vpc_al_c = {bus.vpc[XLEN-1:2], 2'b00};

  // Next-state: exception entry takes precedence and drops mtc0/eret
  always_comb begin
    sr_d          = sr_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    badv_d        = badv_q;
`ifdef CP0_COUNT_EN
    count_d       = count_q + 32'd1;
    compare_d     = compare_q;
    tp_d          = timer_c;
`endif
    cause_d.ip    = hw_eff_c;

    if (req_c) begin
      sr_d.exl         = 1'b1;
      cause_d.exc_code = sel_code_c;
      cause_d.bd       = bus.bd_in;
      epc_d            = bus.bd_in ? (vpc_al_c - 32'd4) : vpc_al_c;
      if (is_addr_exc(sel_code_c)) begin
        badv_d = bus.badvaddr_in;
      end
    end else begin
      if (bus.en) begin
        case (bus.cp0_addr)
          CP0_SR: begin
            sr_d.im  = bus.cp0_in[15:10];
            sr_d.exl = bus.cp0_in[1];
            sr_d.ie  = bus.cp0_in[0];
          end
          CP0_EPC: epc_d = {bus.cp0_in[XLEN-1:2], 2'b00};
`ifdef CP0_COUNT_EN
          CP0_COUNT: count_d = bus.cp0_in;
          CP0_COMPARE: begin
            compare_d = bus.cp0_in;
            tp_d      = 1'b0;
          end
`endif
          default: ;
        endcase
      end
      if (bus.exl_clr) begin
        sr_d.exl = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      cause_q   <= '0;
      epc_q     <= '0;
      badv_q    <= '0;
`ifdef CP0_COUNT_EN
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      tp_q      <= 1'b0;
`endif
    end else begin
      sr_q      <= sr_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      badv_q    <= badv_d;
`ifdef CP0_COUNT_EN
      count_q   <= count_d;
      compare_q <= compare_d;
      tp_q      <= tp_d;
`endif
    end
  end

  // mfc0 read mux; unimplemented indices read zero
  always_comb begin
    bus.cp0_out = '0;
    case (bus.cp0_addr)
      CP0_SR:       bus.cp0_out = {16'b0, sr_q.im, 8'b0, sr_q.exl, sr_q.ie};
      CP0_CAUSE:    bus.cp0_out = {cause_q.bd, 15'b0, cause_q.ip, 3'b0, cause_q.exc_code, 2'b0};
      CP0_EPC:      bus.cp0_out = epc_q;
      CP0_BADVADDR: bus.cp0_out = badv_q;
      CP0_PRID:     bus.cp0_out = PRID;
`ifdef CP0_COUNT_EN
      CP0_COUNT:    bus.cp0_out = count_q;
      CP0_COMPARE:  bus.cp0_out = compare_q;
`endif
      default:      bus.cp0_out = '0;
    endcase
  end

  assign bus.req        = req_c;
  assign bus.epc_out    = epc_q;
  assign bus.handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: self-checking bench for cp0 (vector table, timer sequence when
// CP0_COUNT_EN is defined, and randomized traffic against a word-level model).
module tb_cp0;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  cp0_if bus ();

  cp0 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [31:0] badv;
    logic [5:0]  hw;
    logic        clr;
    logic        exp_req;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic rst, input logic en, input logic [4:0] addr,
                              input logic [31:0] din, input logic [31:0] vpc, input logic bd,
                              input logic [4:0] exc, input logic [31:0] badv, input logic [5:0] hw,
                              input logic clr, input logic exp_req, input logic [31:0] exp_out);
    vec_t v;
    v.rst = rst; v.en = en; v.addr = addr; v.din = din; v.vpc = vpc; v.bd = bd;
    v.exc = exc; v.badv = badv; v.hw = hw; v.clr = clr; v.exp_req = exp_req; v.exp_out = exp_out;
    vt.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    reset           = v.rst;
    bus.en          = v.en;
    bus.cp0_addr    = v.addr;
    bus.cp0_in      = v.din;
    bus.vpc         = v.vpc;
    bus.bd_in       = v.bd;
    bus.exc_in      = v.exc;
    bus.badvaddr_in = v.badv;
    bus.hw_int      = v.hw;
    bus.exl_clr     = v.clr;
  endtask

  task automatic idle(input logic [4:0] addr);
    vec_t v;
    v = '{rst:1'b0, en:1'b0, addr:addr, din:32'h0, vpc:32'h0, bd:1'b0, exc:5'd0,
          badv:32'h0, hw:6'h0, clr:1'b0, exp_req:1'b0, exp_out:32'h0};
    drive(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Word-level architectural model
  logic [31:0] m_sr, m_cause, m_epc, m_badv;

  function automatic logic m_int(input logic [5:0] hw);
    return ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req(input logic rst, input logic [5:0] hw, input logic [4:0] exc);
    if (rst) return 1'b0;
    return m_int(hw) || ((exc != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd8:    return m_badv;
      5'd15:   return 32'h0000_4C3A;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_step(input vec_t v);
    logic        r;
    logic [4:0]  code;
    if (v.rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_badv = 0;
    end else begin
      r = m_req(1'b0, v.hw, v.exc);
      code = m_int(v.hw) ? 5'd0 : v.exc;
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(v.hw) << 10);
      if (r) begin
        m_sr    = m_sr | 32'h2;
        m_cause = (m_cause & ~32'h8000_007C) | (32'(v.bd) << 31) | (32'(code) << 2);
        m_epc   = (v.vpc & ~32'h3) - (v.bd ? 32'd4 : 32'd0);
        if (code == 5'd4 || code == 5'd5) m_badv = v.badv;
      end else begin
        if (v.en && v.addr == 5'd12) m_sr = v.din & 32'h0000_FC03;
        if (v.en && v.addr == 5'd14) m_epc = v.din & ~32'h3;
        if (v.clr) m_sr = m_sr & ~32'h2;
      end
    end
  endtask

  initial begin
    vec_t v;
    logic [4:0] codes [8];
    bit found;
    clk = 1'b0;
    checks = 0;
    failures = 0;
    idle(5'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);

    //  rst en addr din           vpc           bd exc badv          hw     clr req out
    add(1, 0, 12, 32'h0,        32'h0,        0, 4,  32'h0,        6'h00, 0, 0, 32'h0);
    add(1, 0, 13, 32'h0,        32'h0,        0, 4,  32'h0,        6'h00, 0, 0, 32'h0);
    add(0, 0, 14, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0);
    add(0, 0, 8,  32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0);
    add(0, 0, 15, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0000_4C3A);
    add(0, 1, 3,  32'hFFFF_FFFF, 32'h0,       0, 0,  32'h0,        6'h00, 0, 0, 32'h0);
    add(0, 0, 3,  32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0);
    add(0, 1, 12, 32'h0000_FC01, 32'h0,       0, 0,  32'h0,        6'h00, 0, 0, 32'h0);
    add(0, 0, 12, 32'h0,        32'h0000_1000, 0, 0, 32'h0,        6'h04, 0, 1, 32'h0000_FC01);
    add(0, 0, 13, 32'h0,        32'h0,        0, 0,  32'h0,        6'h04, 0, 0, 32'h0000_1000);
    add(0, 0, 14, 32'h0,        32'h0,        0, 0,  32'h0,        6'h04, 0, 0, 32'h0000_1000);
    add(0, 0, 12, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 1, 0, 32'h0000_FC03);
    add(0, 0, 12, 32'h0,        32'hBFC0_0104, 1, 5, 32'h3,        6'h00, 0, 1, 32'h0000_FC01);
    add(0, 0, 14, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'hBFC0_0100);
    add(0, 0, 8,  32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h3);
    add(0, 0, 13, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h8000_0014);
    add(0, 0, 12, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 1, 0, 32'h0000_FC03);
    add(0, 0, 13, 32'h0,        32'h0000_2000, 0, 12, 32'hDEAD,    6'h01, 0, 1, 32'h8000_0014);
    add(0, 0, 13, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0000_0400);
    add(0, 0, 8,  32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 1, 0, 32'h3);
    add(0, 0, 14, 32'h0,        32'h0000_3004, 0, 12, 32'hBEEF,    6'h00, 0, 1, 32'h0000_2000);
    add(0, 0, 13, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0000_0030);
    add(0, 0, 8,  32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h3);
    add(0, 0, 12, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 1, 0, 32'h0000_FC03);
    add(0, 1, 14, 32'h1234,     32'h0000_4000, 0, 8, 32'h0,        6'h00, 1, 1, 32'h0000_3004);
    add(0, 0, 14, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0000_4000);
    add(0, 0, 12, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 1, 0, 32'h0000_FC03);
    add(0, 0, 12, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0000_FC01);
    add(0, 0, 13, 32'h0,        32'h0,        1, 10, 32'h0,        6'h00, 0, 1, 32'h0000_0020);
    add(0, 0, 14, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'hFFFF_FFFC);
    add(0, 0, 13, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 1, 0, 32'h8000_0028);
    add(0, 1, 14, 32'h0000_5677, 32'h0,       0, 0,  32'h0,        6'h00, 0, 0, 32'hFFFF_FFFC);
    add(0, 0, 14, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0000_5674);
    add(0, 1, 12, 32'hFFFF_FFFF, 32'h0,       0, 0,  32'h0,        6'h00, 0, 0, 32'h0000_FC01);
    add(0, 0, 12, 32'h0,        32'h0,        0, 4,  32'h0,        6'h3F, 0, 0, 32'h0000_FC03);
    add(0, 0, 12, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 1, 0, 32'h0000_FC03);
    add(0, 0, 8,  32'h0,        32'h0000_0107, 0, 4, 32'h0000_0107, 6'h00, 0, 1, 32'h3);
    add(0, 0, 14, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0000_0104);
    add(0, 0, 8,  32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 1, 0, 32'h0000_0107);
    add(1, 0, 12, 32'h0,        32'h0,        0, 4,  32'h0,        6'h00, 0, 0, 32'h0000_FC01);
    add(0, 0, 12, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0);
    add(0, 0, 8,  32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0);
    add(0, 0, 14, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0);
    add(0, 0, 13, 32'h0,        32'h0,        0, 0,  32'h0,        6'h00, 0, 0, 32'h0);

    foreach (vt[i]) begin
      drive(vt[i]);
      #1;
      chk($sformatf("vec%0d_req", i), 32'(bus.req), 32'(vt[i].exp_req));
      chk($sformatf("vec%0d_out", i), bus.cp0_out, vt[i].exp_out);
      @(negedge clk);
    end
    chk("handler_pc", bus.handler_pc, 32'hBFC0_0380);

`ifdef CP0_COUNT_EN
    // Timer: Compare=5 with IM[15]/IE set raises req exactly when Count reads 5
    idle(5'd0); reset = 1'b1;
    @(negedge clk);
    idle(5'd11); bus.en = 1'b1; bus.cp0_in = 32'd5;
    @(negedge clk);
    idle(5'd12); bus.en = 1'b1; bus.cp0_in = 32'h0000_8001;
    @(negedge clk);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      idle(5'd9);
      #1;
      if (bus.cp0_out == 32'd5) begin
        found = 1'b1;
        chk("timer_req_at_match", 32'(bus.req), 32'd1);
      end else begin
        chk("timer_req_before_match", 32'(bus.req), 32'd0);
      end
      @(negedge clk);
    end
    chk("timer_reached_5", 32'(found), 32'd1);
    idle(5'd11); bus.en = 1'b1; bus.cp0_in = 32'd1000;
    #1 chk("timer_req_in_handler", 32'(bus.req), 32'd0);
    @(negedge clk);
    idle(5'd12); bus.exl_clr = 1'b1;
    #1 chk("timer_req_at_eret", 32'(bus.req), 32'd0);
    @(negedge clk);
    idle(5'd13);
    #1 chk("timer_req_cleared", 32'(bus.req), 32'd0);
    chk("timer_cause_cleared", bus.cp0_out, 32'h0);
    @(negedge clk);
`endif

    // Randomized traffic against the model
    codes = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
    v = '{rst:1'b1, en:1'b0, addr:5'd0, din:32'h0, vpc:32'h0, bd:1'b0, exc:5'd0,
          badv:32'h0, hw:6'h0, clr:1'b0, exp_req:1'b0, exp_out:32'h0};
    drive(v);
    m_step(v);
    @(negedge clk);
    for (int n = 0; n < 3000; n++) begin
      v.rst  = ($urandom_range(0, 63) == 0);
      v.en   = ($urandom_range(0, 3) == 0);
      v.addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(8, 15));
      v.din  = $urandom;
      v.vpc  = $urandom;
      v.bd   = 1'($urandom);
      v.exc  = codes[$urandom_range(0, 7)];
      v.badv = $urandom;
      v.hw   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h0;
      v.clr  = ($urandom_range(0, 3) == 0);
      if (v.clr) v.en = 1'b0;
      if (v.addr == 5'd9 || v.addr == 5'd11) v.en = 1'b0;
      drive(v);
      #1;
      chk("rnd_req", 32'(bus.req), 32'(m_req(v.rst, v.hw, v.exc)));
`ifdef CP0_COUNT_EN
      if (v.addr != 5'd9 && v.addr != 5'd11)
        chk("rnd_out", bus.cp0_out, m_read(v.addr));
`else
      chk("rnd_out", bus.cp0_out, m_read(v.addr));
`endif
      if (n % 8 == 0) chk("rnd_epc_out", bus.epc_out, m_epc);
      m_step(v);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
